// File: rtl/fpu_add_pipe.sv
// rtl/fpu_add_pipe.sv - three-stage floating-point adder/subtractor, unrounded output with guard bits
module fpu_add_pipe #(
  parameter int EXP_WIDTH   = 8,
  parameter int MANT_WIDTH  = 23,
  parameter int GUARD_WIDTH = 3,
  parameter int ID_WIDTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]  in_a,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]  in_b,
  input  logic                           in_sub,
  input  logic [2:0]                     in_mode,
  input  logic [ID_WIDTH-1:0]            in_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sign,
  output logic [EXP_WIDTH-1:0]           out_exponent,
  output logic [MANT_WIDTH:0]            out_mantissa,
  output logic [GUARD_WIDTH-1:0]         out_guard,
  output logic                           out_nan,
  output logic                           out_inf,
  output logic                           out_zero,
  output logic                           out_overflow,
  output logic [2:0]                     out_mode,
  output logic [ID_WIDTH-1:0]            out_id
);

  // significand: hidden bit, stored mantissa, guard/round/sticky
  localparam int SW = 1 + MANT_WIDTH + GUARD_WIDTH;
  localparam logic [2:0] MODE_RDN = 3'b010;
  localparam logic [EXP_WIDTH-1:0] EXP_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

  // handshake / occupancy
  logic s1_valid, s2_valid, s3_valid;
  logic s3_free, s2_adv, s2_free, s1_adv, in_fire;

  // stage 1 registers
  logic                 s1_sign_l, s1_sign_s;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic [SW-1:0]        s1_sig_l, s1_sig_s;
  logic                 s1_nan, s1_inf, s1_inf_sign;
  logic [2:0]           s1_mode;
  logic [ID_WIDTH-1:0]  s1_id;

  // stage 2 registers
  logic                 s2_sign;
  logic [EXP_WIDTH-1:0] s2_exp;
  logic [SW:0]          s2_sum;
  logic                 s2_nan, s2_inf, s2_inf_sign;
  logic [2:0]           s2_mode;
  logic [ID_WIDTH-1:0]  s2_id;

  // stage 1 combinational: classify, swap, align
  logic                 a_sign, b_sign, a_max, b_max;
  logic                 a_nan, b_nan, a_inf, b_inf;
  logic [EXP_WIDTH-1:0] a_exp, b_exp, a_eff, b_eff;
  logic [MANT_WIDTH-1:0] a_man, b_man;
  logic [SW-1:0]        a_sig, b_sig;
  logic                 swap, c_sign_l, c_sign_s;
  logic [EXP_WIDTH-1:0] c_exp, c_diff;
  logic [SW-1:0]        c_sig_l, c_sig_s, c_lost, c_aligned;
  logic [31:0]          c_sh;
  logic                 c_nan, c_inf, c_inf_sign;

  // stage 2 combinational
  logic [SW:0]          d_sum;
  logic                 d_sign;

  // stage 3 combinational
  logic [31:0]          lz, lim, nsh;
  logic [SW-1:0]        nsig;
  logic [EXP_WIDTH-1:0] nexp;
  logic                 nsign, nzero, novf, nnan, ninf;

  // a stage accepts when empty or when its contents move on this same edge
  always_comb begin
    s3_free  = !s3_valid || out_ready;
    s2_adv   = s2_valid && s3_free;
    s2_free  = !s2_valid || s2_adv;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s1_adv;
    in_fire  = in_valid && in_ready;
  end

  // classify operands, order by effective exponent, align the smaller with sticky
  always_comb begin
    a_sign = in_a[EXP_WIDTH+MANT_WIDTH];
    b_sign = in_b[EXP_WIDTH+MANT_WIDTH] ^ in_sub;
    a_exp  = in_a[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    b_exp  = in_b[EXP_WIDTH+MANT_WIDTH-1:MANT_WIDTH];
    a_man  = in_a[MANT_WIDTH-1:0];
    b_man  = in_b[MANT_WIDTH-1:0];
    a_max  = &a_exp;
    b_max  = &b_exp;
    a_nan  = a_max && (a_man != '0);
    b_nan  = b_max && (b_man != '0);
    a_inf  = a_max && (a_man == '0);
    b_inf  = b_max && (b_man == '0);
    a_eff  = (a_exp == '0) ? EXP_ONE : a_exp;
    b_eff  = (b_exp == '0) ? EXP_ONE : b_exp;
    a_sig  = {(a_exp != '0), a_man, {GUARD_WIDTH{1'b0}}};
    b_sig  = {(b_exp != '0), b_man, {GUARD_WIDTH{1'b0}}};

    swap     = b_eff > a_eff;
    c_exp    = swap ? b_eff : a_eff;
    c_sig_l  = swap ? b_sig : a_sig;
    c_sig_s  = swap ? a_sig : b_sig;
    c_sign_l = swap ? b_sign : a_sign;
    c_sign_s = swap ? a_sign : b_sign;
    c_diff   = swap ? (b_eff - a_eff) : (a_eff - b_eff);

    c_sh = 32'(c_diff);
    if (c_sh > 32'(SW)) c_sh = 32'(SW);
    c_lost    = c_sig_s & ~({SW{1'b1}} << c_sh);
    c_aligned = (c_sig_s >> c_sh) | {{(SW-1){1'b0}}, (c_lost != '0)};

    c_nan      = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
    c_inf      = !c_nan && (a_inf || b_inf);
    c_inf_sign = a_inf ? a_sign : b_sign;
  end

  // magnitude add or subtract; result takes the sign of the larger magnitude
  always_comb begin
    if (s1_sign_l == s1_sign_s) begin
      d_sum  = {1'b0, s1_sig_l} + {1'b0, s1_sig_s};
      d_sign = s1_sign_l;
    end else if (s1_sig_l >= s1_sig_s) begin
      d_sum  = {1'b0, s1_sig_l - s1_sig_s};
      d_sign = s1_sign_l;
    end else begin
      d_sum  = {1'b0, s1_sig_s - s1_sig_l};
      d_sign = s1_sign_s;
    end
    if ((s1_sign_l != s1_sign_s) && (d_sum == '0)) d_sign = (s1_mode == MODE_RDN);
  end

  // normalize: carry shifts right, leading zeros shift left down to the subnormal floor
  always_comb begin
    lz = 32'(SW);
    for (int i = 0; i < SW; i++) begin
      if (s2_sum[i]) lz = 32'(SW - 1 - i);
    end
    lim   = 32'(s2_exp) - 32'd1;
    nsh   = (lz < lim) ? lz : lim;
    nsig  = s2_sum[SW-1:0];
    nexp  = s2_exp;
    nsign = s2_sign;
    nzero = 1'b0;
    novf  = 1'b0;
    nnan  = 1'b0;
    ninf  = 1'b0;
    if (s2_nan) begin
      nnan  = 1'b1;
      nexp  = '1;
      nsig  = {2'b11, {(SW-2){1'b0}}};
      nsign = 1'b0;
    end else if (s2_inf) begin
      ninf  = 1'b1;
      nexp  = '1;
      nsig  = '0;
      nsign = s2_inf_sign;
    end else if (s2_sum == '0) begin
      nzero = 1'b1;
      nexp  = '0;
      nsig  = '0;
    end else if (s2_sum[SW]) begin
      nsig = s2_sum[SW:1] | {{(SW-1){1'b0}}, s2_sum[0]};
      nexp = s2_exp + EXP_ONE;
      novf = &nexp;
    end else if (!s2_sum[SW-1]) begin
      nsig = s2_sum[SW-1:0] << nsh;
      nexp = s2_exp - EXP_WIDTH'(nsh);
      if (!nsig[SW-1]) nexp = '0;
    end
  end

  // stage occupancy; only the valids are reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s2_free)  s2_valid <= s1_valid;
      if (s3_free)  s3_valid <= s2_valid;
    end
  end

  // pipeline data, loaded only on a real transfer into each stage
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_l   <= c_sign_l;
      s1_sign_s   <= c_sign_s;
      s1_exp      <= c_exp;
      s1_sig_l    <= c_sig_l;
      s1_sig_s    <= c_aligned;
      s1_nan      <= c_nan;
      s1_inf      <= c_inf;
      s1_inf_sign <= c_inf_sign;
      s1_mode     <= in_mode;
      s1_id       <= in_id;
    end
    if (s2_free && s1_valid) begin
      s2_sign     <= d_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= d_sum;
      s2_nan      <= s1_nan;
      s2_inf      <= s1_inf;
      s2_inf_sign <= s1_inf_sign;
      s2_mode     <= s1_mode;
      s2_id       <= s1_id;
    end
    if (s3_free && s2_valid) begin
      out_sign     <= nsign;
      out_exponent <= nexp;
      out_mantissa <= nsig[SW-1:GUARD_WIDTH];
      out_guard    <= nsig[GUARD_WIDTH-1:0];
      out_nan      <= nnan;
      out_inf      <= ninf;
      out_zero     <= nzero;
      out_overflow <= novf;
      out_mode     <= s2_mode;
      out_id       <= s2_id;
    end
  end

  assign out_valid = s3_valid;

endmodule

// File: tb/tb_fpu_add_pipe.sv
// tb/tb_fpu_add_pipe.sv - scoreboard testbench for fpu_add_pipe (float32 defaults)
module tb_fpu_add_pipe;

  localparam int E = 8;
  localparam int M = 23;
  localparam int G = 3;
  localparam int I = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sub, out_valid, out_ready, out_sign;
  logic [31:0]   in_a, in_b;
  logic [2:0]    in_mode, out_mode;
  logic [I-1:0]  in_id, out_id;
  logic [E-1:0]  out_exponent;
  logic [M:0]    out_mantissa;
  logic [G-1:0]  out_guard;
  logic          out_nan, out_inf, out_zero, out_overflow;

  typedef struct {
    logic [I-1:0] id;
    logic [2:0]   mode;
    logic         sign;
    logic [E-1:0] exponent;
    logic [M:0]   mant;
    logic [G-1:0] guard;
    logic         nan, inf, zero, ovf;
    logic         chk_sign, chk_exp, chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;

  wire [46:0] out_bus = {out_sign, out_exponent, out_mantissa, out_guard,
                         out_nan, out_inf, out_zero, out_overflow, out_mode, out_id};

  fpu_add_pipe #(.EXP_WIDTH(E), .MANT_WIDTH(M), .GUARD_WIDTH(G), .ID_WIDTH(I)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_mode(in_mode), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa), .out_guard(out_guard),
    .out_nan(out_nan), .out_inf(out_inf), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_mode(out_mode), .out_id(out_id)
  );

  always #5 clk = ~clk;

  // float32 encoding of a small positive integer
  function automatic logic [31:0] int2f(input int n);
    int p = 0;
    logic [31:0] r;
    for (int i = 0; i < 31; i++) if (((n >> i) & 1) != 0) p = i;
    r[31]    = 1'b0;
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(n << (23 - p));
    return r;
  endfunction

  function automatic exp_t mk(input logic s, input logic [E-1:0] ex, input logic [M:0] mn,
                              input logic [G-1:0] gd, input logic nn, input logic nf,
                              input logic zr, input logic ov, input logic cs,
                              input logic ce, input logic cd);
    exp_t e;
    e.id = '0; e.mode = '0;
    e.sign = s; e.exponent = ex; e.mant = mn; e.guard = gd;
    e.nan = nn; e.inf = nf; e.zero = zr; e.ovf = ov;
    e.chk_sign = cs; e.chk_exp = ce; e.chk_data = cd;
    return e;
  endfunction

  function automatic exp_t int_sum(input int n);
    logic [31:0] r;
    r = int2f(n);
    return mk(1'b0, r[30:23], {1'b1, r[22:0]}, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
  endfunction

  // scoreboard: every output handshake pops and compares the oldest expectation
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      popped++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got id=%0d, required no output", out_id);
      end else begin
        me = sb.pop_front();
        checks++;
        if (out_id !== me.id) begin errors++; $display("FAIL out_id: got %0d, required %0d", out_id, me.id); end
        checks++;
        if (out_mode !== me.mode) begin errors++; $display("FAIL out_mode id=%0d: got %0d, required %0d", me.id, out_mode, me.mode); end
        checks++;
        if ({out_nan, out_inf, out_zero, out_overflow} !== {me.nan, me.inf, me.zero, me.ovf}) begin
          errors++;
          $display("FAIL flags id=%0d: got nan/inf/zero/ovf=%b, required %b", me.id,
                   {out_nan, out_inf, out_zero, out_overflow}, {me.nan, me.inf, me.zero, me.ovf});
        end
        if (me.chk_sign) begin
          checks++;
          if (out_sign !== me.sign) begin errors++; $display("FAIL sign id=%0d: got %b, required %b", me.id, out_sign, me.sign); end
        end
        if (me.chk_exp) begin
          checks++;
          if (out_exponent !== me.exponent) begin errors++; $display("FAIL exponent id=%0d: got %h, required %h", me.id, out_exponent, me.exponent); end
        end
        if (me.chk_data) begin
          checks++;
          if ({out_mantissa, out_guard} !== {me.mant, me.guard}) begin
            errors++;
            $display("FAIL mantissa id=%0d: got %h/%b, required %h/%b", me.id, out_mantissa, out_guard, me.mant, me.guard);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [2:0] mode, input logic [I-1:0] id, input exp_t e);
    int n = 0;
    exp_t x;
    x = e; x.id = id; x.mode = mode;
    in_a = a; in_b = b; in_sub = sub; in_mode = mode; in_id = id; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout id=%0d: in_ready stayed 0, required 1", id);
    end else begin
      sb.push_back(x);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_out_valid: got %b, required 0", out_valid); end
    tick();
  endtask

  task automatic test_add();
    int lat = 0;
    bit ok;
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 4'd1,
         mk(1'b0, 8'h80, 24'h800000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency: got %0d cycles, required 3", lat); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_drain: %0d results missing, required 0", sb.size()); end
  endtask

  task automatic test_cancel();
    bit ok;
    send(32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 4'd2,
         mk(1'b0, 8'h00, 24'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 4'd3,
         mk(1'b1, 8'h00, 24'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cancel_drain: %0d results missing, required 0", sb.size()); end
  endtask

  task automatic test_align();
    bit ok;
    send(32'h3F800000, 32'h30800000, 1'b0, 3'b000, 4'd4,
         mk(1'b0, 8'h7F, 24'h800000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'h40400000, 32'h3F800000, 1'b1, 3'b001, 4'd5,
         mk(1'b0, 8'h80, 24'h800000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'hBF800000, 32'h3F000000, 1'b0, 3'b011, 4'd6,
         mk(1'b1, 8'h7E, 24'h800000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'h00000001, 32'h00000001, 1'b0, 3'b100, 4'd7,
         mk(1'b0, 8'h00, 24'h000002, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL align_drain: %0d results missing, required 0", sb.size()); end
  endtask

  task automatic test_special();
    bit ok;
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 4'd8,
         mk(1'b0, 8'hFF, 24'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    send(32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 4'd9,
         mk(1'b0, 8'h00, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h3F800000, 32'hFF800000, 1'b0, 3'b000, 4'd10,
         mk(1'b1, 8'h00, 24'h0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    send(32'h7FC00000, 32'h3F800000, 1'b1, 3'b000, 4'd11,
         mk(1'b0, 8'h00, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 4'd12,
         mk(1'b0, 8'h00, 24'h0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL special_drain: %0d results missing, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int n = 0;
    int popped0;
    bit ok;
    bit have = 1'b0;
    logic [46:0] snap;
    exp_t x;
    out_ready = 1'b0;
    popped0 = popped;
    for (int c = 0; c < 6; c++) begin
      in_a = int2f(idx + 1); in_b = int2f(1); in_sub = 1'b0;
      in_mode = 3'(idx % 5); in_id = I'(idx); in_valid = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin
          snap = out_bus;
          have = 1'b1;
        end else begin
          checks++;
          if (out_bus !== snap) begin errors++; $display("FAIL stall_stable: got %h, required %h", out_bus, snap); end
        end
      end
      if (in_ready) begin
        x = int_sum(idx + 2); x.id = I'(idx); x.mode = 3'(idx % 5);
        sb.push_back(x);
        idx++;
      end
      tick();
    end
    checks++;
    if (idx != 3) begin errors++; $display("FAIL accepts_before_stall: got %0d, required 3", idx); end
    out_ready = 1'b1;
    while (idx < 6 && n < 50) begin
      in_a = int2f(idx + 1); in_b = int2f(1); in_sub = 1'b0;
      in_mode = 3'(idx % 5); in_id = I'(idx); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        x = int_sum(idx + 2); x.id = I'(idx); x.mode = 3'(idx % 5);
        sb.push_back(x);
        idx++;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_drain: %0d results missing, required 0", sb.size()); end
    checks++;
    if (popped - popped0 != 6) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 6", popped - popped0); end
  endtask

  task automatic test_reset_flush();
    bit saw = 1'b0;
    bit ok;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send(int2f(1), int2f(2), 1'b0, 3'b000, I'(13 + k), int_sum(3));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
    for (int k = 0; k < 8; k++) begin
      if (out_valid) saw = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw) begin errors++; $display("FAIL flush_out_valid: got 1 after reset, required 0"); end
    tick();
    send(int2f(2), int2f(3), 1'b0, 3'b001, 4'd0, int_sum(5));
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL flush_recover: %0d results missing, required 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_sub = 1'b0;
    in_a = '0; in_b = '0; in_mode = '0; in_id = '0;
    test_reset();
    test_add();
    test_cancel();
    test_align();
    test_special();
    test_back_to_back();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_pipe.md
FPU_ADD_PIPE -- requirements
Module: fpu_add_pipe

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_WIDTH, default 23, stored mantissa width without the hidden bit.
REQ-003 SHALL have parameter GUARD_WIDTH, default 3, guard/round/sticky bits carried to the rounder, minimum 2.
REQ-004 SHALL have parameter ID_WIDTH, default 4, width of the opaque transaction tag.
REQ-005 SHALL have one clock and a synchronous active-low reset: clk  in  1  clock; rst  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: in_valid  in  1  operand pair valid; in_ready  out  1  block accepts this cycle.
REQ-007 SHALL have ports: in_a, in_b  in  1+EXP_WIDTH+MANT_WIDTH each  IEEE-style {sign, exponent, mantissa}; in_sub  in  1  compute a-b when 1, else a+b.
REQ-008 SHALL have ports: in_mode  in  3  rounding mode, passed through (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100); in_id  in  ID_WIDTH  tag.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_sign  out  1; out_exponent  out  EXP_WIDTH; out_mantissa  out  MANT_WIDTH+1  including the hidden bit; out_guard  out  GUARD_WIDTH.
REQ-010 SHALL have ports: out_nan, out_inf, out_zero, out_overflow  out  1 each; out_mode  out  3; out_id  out  ID_WIDTH.

Function
REQ-011 SHALL be a 3-stage pipeline: S1 classify/align, S2 magnitude add/subtract, S3 normalize; latency 3 cycles, throughput 1 per cycle.
REQ-012 SHALL transfer on in_valid&in_ready and on out_valid&out_ready; each stage SHALL load when it is empty or its downstream stage empties in the same cycle (bubbles collapse); in_ready = !S1_valid | S1 advancing.
REQ-013 SHALL hold all out_* signals stable while out_valid=1 and out_ready=0; results SHALL leave in acceptance order with their in_id and in_mode.
REQ-014 SHALL classify each operand: exp=0 and mant=0 zero; exp=0 and mant!=0 subnormal (hidden bit 0, effective exponent 1); exp all-ones and mant=0 inf; exp all-ones and mant!=0 nan; otherwise normal (hidden bit 1).
REQ-015 SHALL treat in_sub as an inversion of b's sign before any other processing.
REQ-016 SHALL swap operands so the larger effective exponent is first; shift the smaller significand ({hidden, mant, GUARD_WIDTH zeros}) right by the exponent difference, saturating at MANT_WIDTH+GUARD_WIDTH+1, and OR every shifted-out bit into the LSB (sticky).
REQ-017 SHALL add significands for equal signs; for unequal signs it SHALL subtract the smaller magnitude from the larger, and the result sign SHALL be the sign of the larger.
REQ-018 SHALL set the sign of an exact-zero difference to 1 only when mode=RDN, else 0.
REQ-019 on carry-out, S3 SHALL shift right by 1 with sticky, increment exponent, and assert out_overflow when the exponent reaches all-ones.
REQ-020 without carry and with MSB 0, S3 SHALL shift left by min(leading_zeros, exponent-1), subtract that shift from the exponent, and set out_exponent=0 when the result stays subnormal.
REQ-021 SHALL output a zero result as out_exponent=0, out_mantissa=0, out_guard=0, out_zero=1.
REQ-022 SHALL assert out_nan for any nan input, or for inf plus opposite-signed inf after the in_sub inversion; otherwise it SHALL assert out_inf for any inf input, with out_sign equal to the sign of the inf operand.
REQ-023 out_overflow SHALL assert only for finite inputs; out_nan, out_inf and out_overflow SHALL NOT be asserted together.
REQ-024 SHALL be parameter-generic; no widths SHALL be hard-coded for float32.

Reset
REQ-025 on a clk edge with rst=0, all stage valids SHALL clear and out_valid=0; in_ready SHALL be 1 in the first cycle after rst returns to 1.
REQ-026 reset asserted mid-operation SHALL discard all in-flight transactions without producing output.
REQ-027 data registers SHALL need no reset; every out_* other than out_valid is don't-care while out_valid=0.

Verification (float32 defaults)
REQ-028 SHALL check 0x3F800000+0x3F800000, in_sub=0, out_ready=1 -> 3 cycles later: sign 0, exp 0x80, mantissa 0x800000, guard 000, all flags 0.
REQ-029 SHALL check 0x3F800000-0x3F800000 (in_sub=1), mode RNE then RDN -> out_zero=1, exponent 0, sign 0 then 1.
REQ-030 SHALL check 0x3F800000+0x30800000 -> exp 0x7F, mantissa 0x800000, guard 001 (sticky only).
REQ-031 SHALL check 0x7F7FFFFF+0x7F7FFFFF -> out_overflow=1, exp 0xFF; and 0x7F800000+0xFF800000 -> out_nan=1, out_inf=0.
REQ-032 SHALL check back-to-back inputs with ids 0..5 and out_ready held low 6 cycles -> in_ready falls after 3 accepts, outputs stay stable, then ids 0..5 leave in order with no loss or duplication.
REQ-033 SHALL check rst pulsed low for one cycle with 3 transactions in flight -> no out_valid afterwards until new inputs are accepted.
